// File: rtl/real_time_i2c.sv
// real_time_i2c: single-master I2C controller for the RTC subsystem.
// Sends START, a 7-bit address plus R/W, then either streams write bytes
// taken from data_in while enable stays high, or reads one byte into
// data_out; a master NACK and STOP always close a read.
// Every bus state lasts one bit period made of four quarters (q0..q3).
// Each quarter is CLK_DIV system clocks long.
//
// Optional build macro: I2C_NACK_ABORT_EN
//   When defined, the block adds a nack output. A slave NACK in the
//   address or write acknowledge slot sets nack and goes straight to STOP.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   addr      slave address, latched when leaving IDLE
//   data_in   write byte, latched at the start of each write byte
//   enable    level request: start a transfer / keep streaming writes
//   rw_en     0 = write, 1 = read, latched with addr
//   data_out  last byte read, held until the next read completes
//   ready     high only in IDLE
//   i2c_sda   open-drain data line (driven 0 or released)
//   i2c_scl   serial clock, push-pull
//   nack      (I2C_NACK_ABORT_EN only) slave NACK seen, cleared on next START
module real_time_i2c #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw_en,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  output logic       i2c_scl
`ifdef I2C_NACK_ABORT_EN
  ,
  output logic       nack
`endif
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ACK_A,
    S_WDATA,
    S_ACK_W,
    S_RDATA,
    S_MACK,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    dout_q, dout_d;
  logic          rw_q, rw_d;
  logic          sda_oe;
  logic          q_end, samp, bit_end;
`ifdef I2C_NACK_ABORT_EN
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
`endif

  assign q_end   = (div_q == DIV_LAST);
  assign samp    = q_end && (qtr_q == 2'd2);
  assign bit_end = q_end && (qtr_q == 2'd3);

  always_comb begin
    state_d = state_q;
    div_d   = q_end ? '0 : div_q + DW'(1);
    qtr_d   = q_end ? qtr_q + 2'd1 : qtr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    rw_d    = rw_q;
`ifdef I2C_NACK_ABORT_EN
    ack_d   = ack_q;
    nack_d  = nack_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bit_end) begin
          if (enable) begin
            state_d = S_START;
            rw_d    = rw_en;
            sh_d    = {addr, rw_en};
`ifdef I2C_NACK_ABORT_EN
            nack_d  = 1'b0;
`endif
          end else begin
            // Bus-free time has elapsed: park on the last clock so enable
            // is re-checked every cycle from here on.
            div_d = div_q;
            qtr_d = qtr_q;
          end
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_ADDR;
          bit_d   = 3'd7;
        end
      end
      S_ADDR, S_WDATA: begin
        if (bit_end) begin
          sh_d = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd0) begin
            state_d = (state_q == S_ADDR) ? S_ACK_A : S_ACK_W;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      S_ACK_A, S_ACK_W: begin
`ifdef I2C_NACK_ABORT_EN
        if (samp) ack_d = ~i2c_sda;
`endif
        if (bit_end) begin
          bit_d = 3'd7;
          sh_d  = data_in;
          if ((state_q == S_ACK_A) && rw_q) begin
            state_d = S_RDATA;
          end else if ((state_q == S_ACK_A) || enable) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_STOP;
          end
`ifdef I2C_NACK_ABORT_EN
          if (!ack_q) begin
            state_d = S_STOP;
            nack_d  = 1'b1;
          end
`endif
        end
      end
      S_RDATA: begin
        if (samp) sh_d = {sh_q[6:0], i2c_sda};
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            state_d = S_MACK;
            dout_d  = sh_q;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      S_MACK: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      rw_q    <= 1'b0;
`ifdef I2C_NACK_ABORT_EN
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      rw_q    <= rw_d;
`ifdef I2C_NACK_ABORT_EN
      ack_q   <= ack_d;
      nack_q  <= nack_d;
`endif
    end
  end

  // SCL is low in q0/q1 and high in q2/q3 unless the state overrides it.
  always_comb begin
    i2c_scl = qtr_q[1];
    sda_oe  = 1'b0;
    unique case (state_q)
      S_IDLE:          i2c_scl = 1'b1;
      S_START: begin
        i2c_scl = 1'b1;
        sda_oe  = qtr_q[1];
      end
      S_ADDR, S_WDATA: sda_oe = ~sh_q[7];
      S_STOP:          sda_oe = (qtr_q != 2'd3);
      default:         sda_oe = 1'b0;
    endcase
  end

  assign i2c_sda  = sda_oe ? 1'b0 : 1'bz;
  assign data_out = dout_q;
  assign ready    = (state_q == S_IDLE);
`ifdef I2C_NACK_ABORT_EN
  assign nack     = nack_q;
`endif

endmodule

// File: tb/tb_real_time_i2c.sv
// Self-checking bench for real_time_i2c. Two instances (CLK_DIV=1 and 3)
// share the request inputs; each has its own SDA net with a pull-up and a
// bench-side slave that pulls low in acknowledge and read-data slots.
module tb_real_time_i2c;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst3, enable, rw_en;
  logic [6:0] addr;
  logic [7:0] data_in;
  logic [7:0] dout1, dout3;
  logic       rdy1, rdy3, scl1, scl3;
  logic       slv1, slv3;
  wire        sda1, sda3;
`ifdef I2C_NACK_ABORT_EN
  logic       nack1, nack3;
`endif

  pullup pu1 (sda1);
  pullup pu3 (sda3);
  assign sda1 = slv1 ? 1'b0 : 1'bz;
  assign sda3 = slv3 ? 1'b0 : 1'bz;

  real_time_i2c #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .addr(addr), .data_in(data_in), .enable(enable),
    .rw_en(rw_en), .data_out(dout1), .ready(rdy1), .i2c_sda(sda1), .i2c_scl(scl1)
`ifdef I2C_NACK_ABORT_EN
    , .nack(nack1)
`endif
  );

  real_time_i2c #(.CLK_DIV(3)) dut3 (
    .clk(clk), .rst(rst3), .addr(addr), .data_in(data_in), .enable(enable),
    .rw_en(rw_en), .data_out(dout3), .ready(rdy3), .i2c_sda(sda3), .i2c_scl(scl3)
`ifdef I2C_NACK_ABORT_EN
    , .nack(nack3)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef enum {K_IDLE, K_START, K_BIT, K_RBIT, K_ACK, K_REL, K_STOP} kind_t;
  typedef struct { kind_t k; logic v; } slot_t;

  typedef struct {
    logic       sel3;      // run on the CLK_DIV=3 instance
    logic       rw;
    logic [6:0] addr;
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    logic       ack;       // slave acknowledges
    logic [7:0] rdata;     // byte the slave returns on a read
    int         wait_clks; // extra IDLE clocks before enable rises
    logic [7:0] exp_abyte; // expected address byte on SDA
    logic [7:0] exp_dout;  // expected data_out after the transfer
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic slot_t mk(input kind_t k, input logic v);
    slot_t t;
    t.k = k;
    t.v = v;
    return t;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    slot_t      sl[$];
    int         dv, len, q;
    logic       e_scl, e_sda, e_slv;
    logic [7:0] wb;
    logic [7:0] e_dout;
    logic [10:0] got;
    logic       abort;
`ifdef I2C_NACK_ABORT_EN
    abort = 1'b1;
`else
    abort = 1'b0;
`endif
    e_dout = v.sel3 ? 8'h00 : ((idx == 0) ? 8'h00 : vecs[idx-1].exp_dout);
    sl.push_back(mk(K_IDLE, 1'b0));
    sl.push_back(mk(K_START, 1'b0));
    for (int i = 7; i >= 0; i--) sl.push_back(mk(K_BIT, v.exp_abyte[i]));
    sl.push_back(mk(K_ACK, v.ack));
    if (abort && !v.ack) begin
      sl.push_back(mk(K_STOP, 1'b0));
    end else if (v.rw) begin
      for (int i = 7; i >= 0; i--) sl.push_back(mk(K_RBIT, v.rdata[i]));
      sl.push_back(mk(K_REL, 1'b0));
      sl.push_back(mk(K_STOP, 1'b0));
    end else begin
      for (int k = 0; k < v.nbytes; k++) begin
        wb = (k == 0) ? v.b0 : v.b1;
        for (int i = 7; i >= 0; i--) sl.push_back(mk(K_BIT, wb[i]));
        sl.push_back(mk(K_ACK, v.ack));
      end
      sl.push_back(mk(K_STOP, 1'b0));
    end

    dv = v.sel3 ? 3 : 1;
    if (v.sel3) rst3 = 1'b1;
    if (v.wait_clks > 0) enable = 1'b0;
    addr    = v.addr;
    rw_en   = v.rw;
    data_in = v.b0;
    for (int s = 0; s < sl.size(); s++) begin
      len = 4 * dv + ((s == 0) ? v.wait_clks : 0);
      for (int c = 0; c < len; c++) begin
        if (c == 0) begin
          if (s == 2) begin
            addr  = ~v.addr;
            rw_en = ~v.rw;
          end
          if (!v.rw) begin
            for (int k = 0; k < v.nbytes; k++)
              if (s == 10 + 9 * k) data_in = (k == 0) ? v.b0 : v.b1;
            if (s == 11 + 9 * (v.nbytes - 1)) enable = 1'b0;
          end
          if (sl[s].k == K_REL) e_dout = v.exp_dout;
        end
        if (s == 0 && c == len - 1) enable = 1'b1;
        q = c / dv;
        if (q > 3) q = 3;
        e_slv = 1'b0;
        e_scl = (q >= 2);
        e_sda = 1'b1;
        case (sl[s].k)
          K_IDLE:  e_scl = 1'b1;
          K_START: begin e_scl = 1'b1; e_sda = (q < 2); end
          K_BIT:   e_sda = sl[s].v;
          K_RBIT:  begin e_sda = sl[s].v; e_slv = ~sl[s].v; end
          K_ACK:   begin e_sda = ~sl[s].v; e_slv = sl[s].v; end
          K_REL:   e_sda = 1'b1;
          K_STOP:  e_sda = (q == 3);
          default: e_sda = 1'b1;
        endcase
        if (v.sel3) slv3 = e_slv; else slv1 = e_slv;
        #1;
        got = v.sel3 ? {scl3, sda3, rdy3, dout3} : {scl1, sda1, rdy1, dout1};
        chk($sformatf("bus v%0d slot%0d clk%0d scl/sda/rdy/dout", idx, s, c),
            {21'd0, got}, {21'd0, e_scl, e_sda, (sl[s].k == K_IDLE), e_dout});
        @(negedge clk);
      end
    end
    chk($sformatf("dout_end v%0d", idx), {24'd0, v.sel3 ? dout3 : dout1}, {24'd0, v.exp_dout});
`ifdef I2C_NACK_ABORT_EN
    chk($sformatf("nack v%0d", idx), {31'd0, v.sel3 ? nack3 : nack1}, {31'd0, ~v.ack});
`endif
  endtask

  initial begin
    //          sel3  rw    addr   b0     b1     n  ack   rdata  wait abyte  dout
    vecs[0] = '{1'b0, 1'b0, 7'h78, 8'h3C, 8'h3C, 2, 1'b1, 8'h00, 0, 8'hF0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 7'h68, 8'h00, 8'h00, 1, 1'b1, 8'hA5, 0, 8'hD1, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 7'h2A, 8'h81, 8'h00, 1, 1'b1, 8'h00, 0, 8'h54, 8'hA5};
    vecs[3] = '{1'b0, 1'b0, 7'h11, 8'h5A, 8'hFF, 2, 1'b0, 8'h00, 5, 8'h22, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 7'h7F, 8'h00, 8'h00, 1, 1'b1, 8'h00, 0, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 7'h78, 8'h3C, 8'h3C, 2, 1'b1, 8'h00, 0, 8'hF0, 8'h00};

    rst1 = 1'b0; rst3 = 1'b0; slv1 = 1'b0; slv3 = 1'b0;
    enable = 1'b0; rw_en = 1'b0; addr = 7'h78; data_in = 8'h3C;
    repeat (3) @(negedge clk);
    #1;
    chk("reset scl", {31'd0, scl1}, 32'd1);
    chk("reset sda", {31'd0, sda1}, 32'd1);
    chk("reset ready", {31'd0, rdy1}, 32'd1);
    chk("reset dout", {24'd0, dout1}, 32'd0);

    // Reset in the middle of WDATA bit 3 (clock 61 = bit 3, q1).
    @(negedge clk);
    rst1 = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 61; c++) begin
      slv1 = (c >= 40 && c <= 43);
      @(negedge clk);
    end
    slv1 = 1'b0;
    #1;
    chk("mid wdata ready", {31'd0, rdy1}, 32'd0);
    chk("mid wdata scl", {31'd0, scl1}, 32'd0);
    chk("mid wdata sda bit3", {31'd0, sda1}, 32'd1);
    rst1 = 1'b0;
    #1;
    chk("async rst scl", {31'd0, scl1}, 32'd1);
    chk("async rst sda", {31'd0, sda1}, 32'd1);
    chk("async rst ready", {31'd0, rdy1}, 32'd1);
    chk("async rst dout", {24'd0, dout1}, 32'd0);
    repeat (2) @(negedge clk);
    rst1 = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    enable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
